// File: rtl/fetchq_pkg.sv
// Shared types and widths for the fetch-to-decode instruction queue.
package fetchq_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Occupancy counter width: must hold the value DEPTH itself.
  function automatic int unsigned cw_of(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle around the instruction queue.
interface fetch_queue_if
  import fetchq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = cw_of(DEPTH);

  logic               push_valid_F;
  logic               push_ready_F;
  logic [PC_W-1:0]    pc_F;
  logic [INSTR_W-1:0] instr_F;
  logic               flush;
  logic               pop_valid_D;
  logic               pop_ready_D;
  logic [PC_W-1:0]    pc_D;
  logic [INSTR_W-1:0] instr_D;
  logic [CW-1:0]      count;

  // Environment side: fetch, branch redirect and decode.
  modport master (
    output push_valid_F, pc_F, instr_F, flush, pop_ready_D,
    input  push_ready_F, pop_valid_D, pc_D, instr_D, count
  );

  // Queue side.
  modport slave (
    input  push_valid_F, pc_F, instr_F, flush, pop_ready_D,
    output push_ready_F, pop_valid_D, pc_D, instr_D, count
  );

endinterface

// File: rtl/fetchq_ctrl.sv
// Pointer, occupancy and flush control for the fetch queue.
module fetchq_ctrl
  import fetchq_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = cw_of(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_valid,
  input  logic          pop_ready,
  input  logic          flush,
  input  logic          bypass_take,
  output logic          push_ready,
  output logic          q_valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count
);

  logic pop_en;

  // A full queue refuses pushes even when a pop happens in the same cycle.
  assign push_ready = reset && (count != CW'(DEPTH));
  assign q_valid    = reset && !flush && (count != '0);
  // An entry consumed through the bypass path is never written.
  assign wr_en      = push_valid && push_ready && !flush && !bypass_take;
  assign pop_en     = q_valid && pop_ready;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + AW'(1);
      if (pop_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (count <= CW'(DEPTH));
      assert (!(pop_en && (count == '0)));
      assert (!(wr_en && (count == CW'(DEPTH))));
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: storage, head mux and optional bypass.
// Define FETCHQ_BYPASS_EN for a zero-latency path when the queue is empty.
module fetch_queue
  import fetchq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cw_of(DEPTH);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          q_valid;
  logic          wr_en;
  logic          byp_active;
  logic          byp_take;

  fetchq_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .push_valid  (bus.push_valid_F),
    .pop_ready   (bus.pop_ready_D),
    .flush       (bus.flush),
    .bypass_take (byp_take),
    .push_ready  (bus.push_ready_F),
    .q_valid     (q_valid),
    .wr_en       (wr_en),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count)
  );

  assign bus.count = count;

  // Storage needs no reset; occupancy masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= '{pc: bus.pc_F, instr: bus.instr_F};
  end

  assign head = mem[rd_ptr];

`ifdef FETCHQ_BYPASS_EN
  assign byp_active = reset && !bus.flush && bus.push_valid_F && (count == '0);
`else
  assign byp_active = 1'b0;
`endif
  assign byp_take = byp_active && bus.pop_ready_D;

  always_comb begin
    bus.pop_valid_D = q_valid;
    bus.pc_D        = '0;
    bus.instr_D     = '0;
    if (q_valid) begin
      bus.pc_D    = head.pc;
      bus.instr_D = head.instr;
    end
`ifdef FETCHQ_BYPASS_EN
    else if (byp_active) begin
      bus.pop_valid_D = 1'b1;
      bus.pc_D        = bus.pc_F;
      bus.instr_D     = bus.instr_F;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector bench for fetch_queue; expectations follow FETCHQ_BYPASS_EN.
module tb_fetch_queue;
  import fetchq_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = cw_of(DEPTH);
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    bit          rst;
    bit          pv;
    logic [63:0] pc;
    bit          pr;
    bit          fl;
    bit          e_pready;
    bit          e_pvalid;
    logic [63:0] e_pc;
    int          e_cnt;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs[$];

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ipat(input logic [63:0] pc);
    return pc[31:0] ^ 32'h1300_0013;
  endfunction

  task automatic add(input bit rst, input bit pv, input logic [63:0] pc, input bit pr,
                     input bit fl, input bit e_pready, input bit e_pvalid,
                     input logic [63:0] e_pc, input int e_cnt);
    vec_t v;
    v.rst = rst; v.pv = pv; v.pc = pc; v.pr = pr; v.fl = fl;
    v.e_pready = e_pready; v.e_pvalid = e_pvalid; v.e_pc = e_pc; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit rst, input bit pv, input logic [63:0] pc, input bit pr,
                       input bit fl);
    reset            = rst;
    bus.push_valid_F = pv;
    bus.pc_F         = pc;
    bus.instr_F      = ipat(pc);
    bus.pop_ready_D  = pr;
    bus.flush        = fl;
  endtask

  task automatic check(input string tag, input bit e_pready, input bit e_pvalid,
                       input logic [63:0] e_pc, input int e_cnt);
    logic [31:0] e_instr;
    e_instr = e_pvalid ? ipat(e_pc) : 32'h0;
    total += 5;
    if (bus.push_ready_F !== e_pready) begin
      bad++;
      $display("FAIL %s push_ready_F got=%0b exp=%0b", tag, bus.push_ready_F, e_pready);
    end
    if (bus.pop_valid_D !== e_pvalid) begin
      bad++;
      $display("FAIL %s pop_valid_D got=%0b exp=%0b", tag, bus.pop_valid_D, e_pvalid);
    end
    if (bus.pc_D !== e_pc) begin
      bad++;
      $display("FAIL %s pc_D got=%h exp=%h", tag, bus.pc_D, e_pc);
    end
    if (bus.instr_D !== e_instr) begin
      bad++;
      $display("FAIL %s instr_D got=%h exp=%h", tag, bus.instr_D, e_instr);
    end
    if (bus.count !== CW'(e_cnt)) begin
      bad++;
      $display("FAIL %s count got=%0d exp=%0d", tag, bus.count, e_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // rst pv pc pr fl | push_ready pop_valid pc_D count (pre-edge)
    add(0, 1, 64'h999, 1, 0, 0, 0, 64'h0, 0);
    add(0, 0, 64'h0,   0, 0, 0, 0, 64'h0, 0);
    add(1, 0, 64'h0,   0, 0, 1, 0, 64'h0, 0);
    // fill to full, refused fifth push, full with simultaneous pop, drain
    add(1, 1, 64'h0,   0, 0, 1, BYP, 64'h0, 0);
    add(1, 1, 64'h4,   0, 0, 1, 1, 64'h0, 1);
    add(1, 1, 64'h8,   0, 0, 1, 1, 64'h0, 2);
    add(1, 1, 64'hC,   0, 0, 1, 1, 64'h0, 3);
    add(1, 1, 64'h10,  0, 0, 0, 1, 64'h0, 4);
    add(1, 1, 64'h10,  1, 0, 0, 1, 64'h0, 4);
    add(1, 0, 64'h0,   1, 0, 1, 1, 64'h4, 3);
    add(1, 0, 64'h0,   1, 0, 1, 1, 64'h8, 2);
    add(1, 0, 64'h0,   1, 0, 1, 1, 64'hC, 1);
    add(1, 0, 64'h0,   1, 0, 1, 0, 64'h0, 0);
    // build count=2 then stream 10 cycles across pointer wrap
    add(1, 1, 64'h20,  0, 0, 1, BYP, BYP ? 64'h20 : 64'h0, 0);
    add(1, 1, 64'h24,  0, 0, 1, 1, 64'h20, 1);
    for (int k = 0; k < 10; k++)
      add(1, 1, 64'h28 + 64'(4 * k), 1, 0, 1, 1, 64'h20 + 64'(4 * k), 2);
    // count=3, then flush with a colliding push
    add(1, 1, 64'h50,  0, 0, 1, 1, 64'h48, 2);
    add(1, 1, 64'h40,  1, 1, 1, 0, 64'h0, 3);
    add(1, 0, 64'h0,   1, 0, 1, 0, 64'h0, 0);
    add(1, 1, 64'h100, 0, 0, 1, BYP, BYP ? 64'h100 : 64'h0, 0);
    add(1, 0, 64'h0,   0, 0, 1, 1, 64'h100, 1);
    // mid-operation reset at count=3
    add(1, 1, 64'h104, 0, 0, 1, 1, 64'h100, 1);
    add(1, 1, 64'h108, 0, 0, 1, 1, 64'h100, 2);
    add(0, 1, 64'h10C, 1, 0, 0, 0, 64'h0, 3);
    add(1, 0, 64'h0,   1, 0, 1, 0, 64'h0, 0);

    // one unchecked reset edge so the counter has a defined value
    drive(0, 0, 64'h0, 0, 0);
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].pv, vecs[i].pc, vecs[i].pr, vecs[i].fl);
      #2;
      check($sformatf("vec%0d", i), vecs[i].e_pready, vecs[i].e_pvalid,
            vecs[i].e_pc, vecs[i].e_cnt);
      tick();
    end

    // empty-queue push with decode ready: same-cycle with bypass, else next cycle
    drive(1, 1, 64'h200, 1, 0);
    #2;
    check("byp_push", 1, BYP, BYP ? 64'h200 : 64'h0, 0);
    tick();
    drive(1, 0, 64'h0, 1, 0);
    #2;
    check("byp_next", 1, !BYP, BYP ? 64'h0 : 64'h200, BYP ? 0 : 1);
    tick();
    #2;
    check("byp_idle", 1, 0, 64'h0, 0);
    tick();

    // flush on an empty queue with a push pending, then push accepted next cycle
    drive(1, 1, 64'h300, 1, 1);
    #2;
    check("fl_empty", 1, 0, 64'h0, 0);
    tick();
    drive(1, 1, 64'h304, 0, 0);
    #2;
    check("fl_after", 1, BYP, BYP ? 64'h304 : 64'h0, 0);
    tick();
    drive(1, 0, 64'h0, 0, 0);
    #2;
    check("fl_head", 1, 1, 64'h304, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue directly downstream of the fetch stage, feeding decode.
- Buffers {PC, instruction} pairs from fetch plus instruction memory, so a decode stall does not immediately stall PC update.
- Provides valid/ready handshakes on both sides.
- Flushes all buffered entries when a taken branch redirects fetch (PCSrc).

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, at least 2.
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- push_valid_F  in  1  fetch presents a valid entry
- push_ready_F  out  1  queue accepts; fetch holds PC while low
- pc_F  in  64  PC of the entry (imem address)
- instr_F  in  32  instruction word read at pc_F
- flush  in  1  taken branch/redirect; discard all entries
- pop_valid_D  out  1  head entry valid for decode
- pop_ready_D  in  1  decode consumes head
- pc_D  out  64  head PC
- instr_D  out  32  head instruction
- count  out  CW  current occupancy, 0..DEPTH

Behaviour:
- Reset:
  - Sampled on the rising edge while reset==0.
  - rd_ptr, wr_ptr and count are cleared to 0.
  - Storage contents are don't-care.
  - While reset==0: push_ready_F=0, pop_valid_D=0, pc_D=0, instr_D=0.
- Push: occurs at an edge when push_valid_F && push_ready_F && !flush.
  - Writes the entry at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop: occurs at an edge when pop_valid_D && pop_ready_D.
  - rd_ptr advances and wraps modulo DEPTH.
- Ready and valid:
  - push_ready_F = reset && (count != DEPTH). A full queue does not accept a push, even with a simultaneous pop.
  - pop_valid_D = reset && !flush && (count != 0).
- Head outputs:
  - pc_D/instr_D read combinationally from the head entry at rd_ptr.
  - Both are forced to 0 when pop_valid_D==0.
- Latency: an entry pushed at edge N is visible on the pop outputs from cycle N+1 (one cycle minimum).
- Simultaneous push and pop when 0<count<DEPTH: count is unchanged and both pointers advance.
- Order: strict FIFO; no reordering.
- Full: count==DEPTH deasserts push_ready_F; the push is not taken and no data is overwritten.
- Empty: count==0 deasserts pop_valid_D; pop_ready_D is ignored.
- Flush:
  - Has priority over push and pop in the same cycle.
  - At the edge, pointers and count clear to 0.
  - The push presented that cycle is dropped.
  - pop_valid_D is masked low in the flush cycle, so decode never consumes a squashed entry.
  - A push in the cycle after flush is accepted normally.
- Reset mid-operation: same result as reset from idle; all entries are lost.
- Count arithmetic: CW bits, never exceeds DEPTH and never underflows. Either violation is an assertion failure in verification.

Optional Feature:
- Macro: FETCHQ_BYPASS_EN.
- Defined:
  - When count==0, push_valid_F==1 and flush==0, the input passes combinationally to the outputs: pop_valid_D=1, pc_D=pc_F, instr_D=instr_F.
  - If pop_ready_D is also 1, the entry is consumed that cycle and not written; count stays 0. This gives zero-cycle latency.
  - If pop_ready_D==0, the entry is written normally.
- Undefined: the one-cycle minimum latency above applies and there is no combinational path from the F inputs to the D outputs.

Decomposition:
- Package fetchq_pkg:
  - typedef fetch_entry_t: packed struct {logic [63:0] pc; logic [31:0] instr;}.
  - Constants PC_W=64 and INSTR_W=32.
- Sub-module fetchq_ctrl: pointer, count, full/empty and flush logic, parameterized by DEPTH.
- Top level: entry storage array, head read mux and optional bypass.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> push_ready_F=1, pop_valid_D=0, count=0, pc_D=0.
- Fill and drain: push PCs 0x0,0x4,0x8,0xC with pop_ready_D=0 -> count=4 and push_ready_F=0; a fifth push of 0x10 is not taken. Raise pop_ready_D -> pc_D sequence 0x0,0x4,0x8,0xC, then pop_valid_D=0.
- Steady stream: continuous push and pop from count=2 for 10 cycles -> count stays 2; the PC sequence is in order across pointer wrap.
- Flush: count=3 with flush=1 and push_valid_F=1 (pc_F=0x40) in the same cycle -> pop_valid_D=0 that cycle; next cycle count=0 and 0x40 is absent. Then push 0x100 -> pc_D=0x100 one cycle later.
- Mid-operation reset: count=3, assert reset for 1 cycle -> count=0 and pop_valid_D=0 after the edge.
- Bypass (FETCHQ_BYPASS_EN): empty queue, push pc_F=0x200 with pop_ready_D=1 -> pc_D=0x200 in the same cycle and count stays 0. Without the macro, pc_D=0x200 appears one cycle later.
